// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM state codes and request-legality helper
// for the read-channel slave and its address generator.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4mm_read_slave_mem_if.sv
// AR/R channel bundle between a DMA read master and the memory read slave.
interface axi4mm_read_slave_mem_if #(
  parameter int ID_W           = 2,
  parameter int DATA_SIZE      = 32,
  parameter int MEMORY_STORAGE = 20
);

  logic                      arvalid;
  logic                      arready;
  logic [ID_W-1:0]           arid;
  logic [MEMORY_STORAGE-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_SIZE-1:0]      rdata;
  logic [ID_W-1:0]           rid;
  logic [1:0]                rresp;
  logic                      rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );

endinterface

// File: rtl/axi4mm_read_slave_mem_chk.sv
// Protocol checks on the R channel: held beats stay stable, and no AR
// acceptance while a beat is outstanding.
module axi4mm_read_slave_mem_chk #(
  parameter int DATA_SIZE = 32,
  parameter int ID_W      = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 arready,
  input logic                 rvalid,
  input logic                 rready,
  input logic [DATA_SIZE-1:0] rdata,
  input logic [ID_W-1:0]      rid,
  input logic [1:0]           rresp,
  input logic                 rlast
);

  a_r_stable: assert property (@(posedge clk) disable iff (rst)
    (rvalid && !rready) |=> (rvalid && $stable(rdata) && $stable(rid) &&
                             $stable(rresp) && $stable(rlast)));

  a_no_ar_during_r: assert property (@(posedge clk) disable iff (rst)
    rvalid |-> !arready);

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and request legality for AXI4 bursts;
// shared between the read and write channel slaves.
module axi_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int DATA_SIZE = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);

  localparam int MAX_SIZE = $clog2(DATA_SIZE / 8);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1'b1);

  logic [ADDR_W-1:0] step_s;
  logic [ADDR_W-1:0] incr_s;
  logic [ADDR_W-1:0] wrap_mask_s;
  logic [ADDR_W-1:0] wrap_s;

  // Candidate addresses; the wrap window is (len+1) beats of 2**size bytes
  always_comb begin
    step_s      = ONE << size;
    incr_s      = addr + step_s;
    wrap_mask_s = ((ADDR_W'(len) + ONE) << size) - ONE;
    wrap_s      = (addr & ~wrap_mask_s) | (incr_s & wrap_mask_s);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_s;
      BURST_WRAP:  next_addr = wrap_s;
      default:     next_addr = addr;
    endcase
  end

  // Request legality is a property of the whole burst, evaluated on its first beat
  always_comb begin
    if (burst == BURST_RSVD) begin
      illegal = 1'b1;
    end else if (size > 3'(MAX_SIZE)) begin
      illegal = 1'b1;
    end else if ((burst == BURST_WRAP) &&
                 (!wrap_len_ok(len) || ((addr & (step_s - ONE)) != '0))) begin
      illegal = 1'b1;
    end else begin
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/axi4mm_read_slave_mem.sv
// AXI4 read-channel slave over an internal word memory with a side preload port;
// one burst at a time, beats registered and loaded on the handshake edge.
module axi4mm_read_slave_mem
  import axi4_pkg::*;
#(
  parameter int DATA_SIZE      = 32,
  parameter int ID_W           = 2,
  parameter int MEMORY_STORAGE = 20,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input logic                      aclk,
  input logic                      areset,
  axi4mm_read_slave_mem_if.slave   axi,
  input logic                      mem_we,
  input logic [MEM_WORDS_LOG2-1:0] mem_waddr,
  input logic [DATA_SIZE-1:0]      mem_wdata
);

  localparam int WORD_SHIFT = $clog2(DATA_SIZE / 8);
  localparam int DEPTH      = 2 ** MEM_WORDS_LOG2;
  localparam int IDX_W      = MEMORY_STORAGE - WORD_SHIFT;

  logic [DATA_SIZE-1:0]      mem_r [0:DEPTH-1];

  logic [0:0]                state_r;
  logic                      arready_r;
  logic                      rvalid_r;
  logic                      rlast_r;
  logic [DATA_SIZE-1:0]      rdata_r;
  logic [ID_W-1:0]           rid_r;
  logic [1:0]                rresp_r;
  logic [MEMORY_STORAGE-1:0] addr_r;
  logic [7:0]                len_r;
  logic [7:0]                beat_r;
  logic [2:0]                size_r;
  logic [1:0]                burst_r;
  logic                      err_r;

  logic                      ar_hs_s;
  logic                      r_hs_s;
  logic [MEMORY_STORAGE-1:0] gen_addr_s;
  logic [7:0]                gen_len_s;
  logic [2:0]                gen_size_s;
  logic [1:0]                gen_burst_s;
  logic [MEMORY_STORAGE-1:0] gen_next_s;
  logic                      gen_illegal_s;
  logic [MEMORY_STORAGE-1:0] load_addr_s;
  logic                      load_err_s;
  logic                      load_last_s;
  logic                      load_en_s;
  logic [IDX_W-1:0]          idx_s;
  logic                      oob_s;
  logic [DATA_SIZE-1:0]      beat_data_s;
  logic [1:0]                beat_resp_s;

  // In IDLE the generator vets the incoming request; in BURST it steps the latched one
  always_comb begin
    if (state_r == IDLE) begin
      gen_addr_s  = axi.araddr;
      gen_len_s   = axi.arlen;
      gen_size_s  = axi.arsize;
      gen_burst_s = axi.arburst;
    end else begin
      gen_addr_s  = addr_r;
      gen_len_s   = len_r;
      gen_size_s  = size_r;
      gen_burst_s = burst_r;
    end
  end

  axi_burst_addr_gen #(
    .ADDR_W    (MEMORY_STORAGE),
    .DATA_SIZE (DATA_SIZE)
  ) u_addr_gen (
    .addr      (gen_addr_s),
    .size      (gen_size_s),
    .len       (gen_len_s),
    .burst     (gen_burst_s),
    .next_addr (gen_next_s),
    .illegal   (gen_illegal_s)
  );

  // Selects which beat is loaded into the output registers at this edge, if any
  always_comb begin
    ar_hs_s = axi.arvalid && arready_r;
    r_hs_s  = rvalid_r && axi.rready;
    if (state_r == IDLE) begin
      load_addr_s = axi.araddr;
      load_err_s  = gen_illegal_s;
      load_last_s = (axi.arlen == 8'd0);
      load_en_s   = ar_hs_s;
    end else begin
      load_addr_s = gen_next_s;
      load_err_s  = err_r;
      load_last_s = ((beat_r + 8'd1) == len_r);
      load_en_s   = r_hs_s && !rlast_r;
    end
  end

  // Out-of-range words fail individually; illegal requests fail every beat
  always_comb begin
    idx_s = load_addr_s[MEMORY_STORAGE-1:WORD_SHIFT];
    oob_s = ((idx_s >> MEM_WORDS_LOG2) != '0);
    if (load_err_s || oob_s) begin
      beat_data_s = '0;
      beat_resp_s = RESP_SLVERR;
    end else begin
      beat_data_s = mem_r[idx_s[MEM_WORDS_LOG2-1:0]];
      beat_resp_s = RESP_OKAY;
    end
  end

  // Preload port; the beat register samples the pre-write word on a colliding edge
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      mem_r[mem_waddr] <= mem_wdata;
    end
  end

  // Burst FSM, beat counter and registered R-channel outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r   <= IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rdata_r   <= '0;
      rid_r     <= '0;
      rresp_r   <= RESP_OKAY;
      addr_r    <= '0;
      len_r     <= 8'd0;
      beat_r    <= 8'd0;
      size_r    <= 3'd0;
      burst_r   <= BURST_FIXED;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          arready_r <= !ar_hs_s;
          if (ar_hs_s) begin
            state_r  <= BURST;
            rid_r    <= axi.arid;
            addr_r   <= axi.araddr;
            len_r    <= axi.arlen;
            size_r   <= axi.arsize;
            burst_r  <= axi.arburst;
            err_r    <= gen_illegal_s;
            beat_r   <= 8'd0;
            rvalid_r <= 1'b1;
            rdata_r  <= beat_data_s;
            rresp_r  <= beat_resp_s;
            rlast_r  <= load_last_s;
          end
        end
        BURST: begin
          if (r_hs_s && rlast_r) begin
            state_r   <= IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
          end else if (load_en_s) begin
            addr_r  <= gen_next_s;
            beat_r  <= beat_r + 8'd1;
            rdata_r <= beat_data_s;
            rresp_r <= beat_resp_s;
            rlast_r <= load_last_s;
          end
        end
        default: begin
          state_r   <= IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

  assign axi.arready = arready_r;
  assign axi.rvalid  = rvalid_r;
  assign axi.rdata   = rdata_r;
  assign axi.rid     = rid_r;
  assign axi.rresp   = rresp_r;
  assign axi.rlast   = rlast_r;

  axi4mm_read_slave_mem_chk #(
    .DATA_SIZE (DATA_SIZE),
    .ID_W      (ID_W)
  ) u_chk (
    .clk     (aclk),
    .rst     (areset),
    .arready (arready_r),
    .rvalid  (rvalid_r),
    .rready  (axi.rready),
    .rdata   (rdata_r),
    .rid     (rid_r),
    .rresp   (rresp_r),
    .rlast   (rlast_r)
  );

endmodule

// File: tb/tb_axi4mm_read_slave_mem.sv
// Directed bench for axi4mm_read_slave_mem: INCR/WRAP/FIXED bursts, stalls,
// illegal requests, out-of-range beats and mid-burst reset.
module tb_axi4mm_read_slave_mem;

  logic        aclk = 1'b0;
  logic        areset;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data [0:7];
  logic [1:0]  exp_resp [0:7];
  logic [1:0]  exp_id;

  axi4mm_read_slave_mem_if #(.ID_W(2), .DATA_SIZE(32), .MEMORY_STORAGE(20)) axi ();

  axi4mm_read_slave_mem #(
    .DATA_SIZE(32), .ID_W(2), .MEMORY_STORAGE(20), .MEM_WORDS_LOG2(10)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .axi       (axi),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input logic [9:0] idx, input logic [31:0] data);
    mem_we    = 1'b1;
    mem_waddr = idx;
    mem_wdata = data;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic set_exp(input int i, input logic [31:0] d, input logic [1:0] r);
    exp_data[i] = d;
    exp_resp[i] = r;
  endtask

  task automatic ar_send(input string tag, input logic [1:0] id, input logic [19:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int w = 0;
    axi.arvalid = 1'b1;
    axi.arid    = id;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = burst;
    while (axi.arready !== 1'b1 && w < 16) begin
      tick();
      w++;
    end
    check({tag, " arready before AR"}, axi.arready, 1'b1);
    tick();
    axi.arvalid = 1'b0;
    exp_id = id;
    check({tag, " rvalid 1 cycle after AR"}, axi.rvalid, 1'b1);
    check({tag, " arready low in burst"}, axi.arready, 1'b0);
  endtask

  // Walks the burst with a 4-cycle rready pattern, checking every presented cycle
  task automatic read_burst(input string tag, input int n, input logic [3:0] pat);
    int b = 0;
    int cyc = 0;
    while (b < n && cyc < 64) begin
      axi.rready = pat[cyc % 4];
      check($sformatf("%s rvalid b%0d", tag, b), axi.rvalid, 1'b1);
      check($sformatf("%s rdata b%0d", tag, b), axi.rdata, exp_data[b]);
      check($sformatf("%s rresp b%0d", tag, b), axi.rresp, exp_resp[b]);
      check($sformatf("%s rid b%0d", tag, b), axi.rid, exp_id);
      check($sformatf("%s rlast b%0d", tag, b), axi.rlast, (b == n - 1));
      if (axi.rready) b++;
      tick();
      cyc++;
    end
    axi.rready = 1'b0;
    check({tag, " handshakes"}, b, n);
    check({tag, " rvalid after last"}, axi.rvalid, 1'b0);
    check({tag, " arready after last"}, axi.arready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    areset      = 1'b1;
    mem_we      = 1'b0;
    mem_waddr   = 10'd0;
    mem_wdata   = 32'd0;
    axi.arvalid = 1'b0;
    axi.arid    = 2'd0;
    axi.araddr  = 20'd0;
    axi.arlen   = 8'd0;
    axi.arsize  = 3'd0;
    axi.arburst = 2'b00;
    axi.rready  = 1'b0;
    exp_id      = 2'd0;

    tick();
    check("reset arready", axi.arready, 1'b0);
    check("reset rvalid", axi.rvalid, 1'b0);
    check("reset rlast", axi.rlast, 1'b0);
    check("reset rresp", axi.rresp, 2'b00);
    check("reset rid", axi.rid, 2'd0);
    check("reset rdata", axi.rdata, 32'd0);
    areset = 1'b0;
    tick();
    check("arready after reset", axi.arready, 1'b1);

    for (int i = 0; i < 8; i++) mem_write(10'(i), 32'hA0 + 32'(i));
    mem_write(10'd1022, 32'h0000_B0B0);
    mem_write(10'd1023, 32'h0000_B1B1);

    // 1: INCR from 0, four beats
    for (int i = 0; i < 4; i++) set_exp(i, 32'hA0 + 32'(i), 2'b00);
    ar_send("incr", 2'd1, 20'h0, 8'd3, 3'd2, 2'b01);
    read_burst("incr", 4, 4'b1111);

    // 2: WRAP from 0x8 visits words 2,3,0,1
    set_exp(0, 32'hA2, 2'b00);
    set_exp(1, 32'hA3, 2'b00);
    set_exp(2, 32'hA0, 2'b00);
    set_exp(3, 32'hA1, 2'b00);
    ar_send("wrap", 2'd2, 20'h8, 8'd3, 3'd2, 2'b10);
    read_burst("wrap", 4, 4'b1111);

    // 3: FIXED at word 1 with rready 1,0,0,1 stalls
    for (int i = 0; i < 3; i++) set_exp(i, 32'hA1, 2'b00);
    ar_send("fixed", 2'd3, 20'h4, 8'd2, 3'd2, 2'b00);
    read_burst("fixed", 3, 4'b1001);

    // 4: reserved burst type, whole burst SLVERR
    for (int i = 0; i < 2; i++) set_exp(i, 32'd0, 2'b10);
    ar_send("rsvd", 2'd0, 20'h0, 8'd1, 3'd2, 2'b11);
    read_burst("rsvd", 2, 4'b1111);

    // 4b: WRAP with 3 beats is illegal
    for (int i = 0; i < 3; i++) set_exp(i, 32'd0, 2'b10);
    ar_send("wrap3", 2'd1, 20'h0, 8'd2, 3'd2, 2'b10);
    read_burst("wrap3", 3, 4'b1111);

    // 4c: arsize wider than the bus is illegal
    for (int i = 0; i < 2; i++) set_exp(i, 32'd0, 2'b10);
    ar_send("wide", 2'd2, 20'h0, 8'd1, 3'd3, 2'b01);
    read_burst("wide", 2, 4'b1111);

    // 5: INCR running off the end of memory
    set_exp(0, 32'h0000_B0B0, 2'b00);
    set_exp(1, 32'h0000_B1B1, 2'b00);
    set_exp(2, 32'd0, 2'b10);
    set_exp(3, 32'd0, 2'b10);
    ar_send("edge", 2'd3, 20'hFF8, 8'd3, 3'd2, 2'b01);
    read_burst("edge", 4, 4'b1111);

    // 6: reset during beat 2 of an 8-beat burst
    ar_send("abort", 2'd3, 20'h0, 8'd7, 3'd2, 2'b01);
    check("abort rdata b0", axi.rdata, 32'hA0);
    axi.rready = 1'b1;
    tick();
    check("abort rdata b1", axi.rdata, 32'hA1);
    check("abort rlast b1", axi.rlast, 1'b0);
    areset = 1'b1;
    tick();
    check("abort rvalid", axi.rvalid, 1'b0);
    check("abort rlast", axi.rlast, 1'b0);
    check("abort rdata", axi.rdata, 32'd0);
    check("abort arready in reset", axi.arready, 1'b0);
    areset     = 1'b0;
    axi.rready = 1'b0;
    tick();
    check("abort arready after release", axi.arready, 1'b1);
    check("abort rvalid after release", axi.rvalid, 1'b0);

    set_exp(0, 32'hA4, 2'b00);
    set_exp(1, 32'hA5, 2'b00);
    ar_send("post", 2'd1, 20'h10, 8'd1, 3'd2, 2'b01);
    read_burst("post", 2, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
